muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide engine for the cpu55 datapath, executing MULT, MULTU, DIV and DIVU. It latches two operands on a start pulse, computes over a fixed number of cycles, and presents a 64-bit result as `hi`/`lo` with a one-cycle `done` pulse. `done` drives the write enables of the downstream HI and LO `myreg` instances; `hi`/`lo` drive their `data_in`.

## Interface
- No parameters. Width is fixed at 32 bits; iteration count is fixed at 32.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset. 0 = reset asserted.
- `start`  in  1  request; sampled only while `busy`=0.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- `a`  in  32  multiplicand / dividend. Sampled with `start`.
- `b`  in  32  multiplier / divisor. Sampled with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid in that cycle.
- `hi`  out  32  multiply: product[63:32]; divide: remainder.
- `lo`  out  32  multiply: product[31:0]; divide: quotient.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - `start`=1 latches `op`, `a` and `b`.
  - Signed ops (MULT, DIV) latch the absolute values of the operands, plus the result-sign and remainder-sign flags.
  - Iteration counter is cleared to 0; next state is CALC.
- **CALC**
  - Runs exactly 32 cycles. The counter increments each cycle; on count 31 the next state is FIX.
  - Multiply uses shift-add over the unsigned magnitudes into a 64-bit accumulator.
  - Divide uses restoring division over the unsigned magnitudes, producing a 32-bit quotient and a 32-bit remainder.
- **FIX**
  - Applies two's-complement negation where needed and registers `hi`/`lo`.
  - Pulses `done` and returns to IDLE.
- Sign rules:
  - MULT: the product is negated when exactly one operand is negative.
  - DIV: the quotient is negated when the operand signs differ. The remainder takes the dividend's sign (truncating division).
  - MULTU and DIVU: no sign handling.
- Divide by zero (`b`=0, DIV or DIVU): `lo`=32'hFFFFFFFF, `hi`=`a` exactly as latched. No sign fix is applied and no exception is raised.
- Signed overflow (DIV 32'h80000000 / 32'hFFFFFFFF): `lo`=32'h80000000, `hi`=0.
- The magnitude of 32'h80000000 is treated as the unsigned value 2^31. Negation is modulo 2^32 (or 2^64 for the product).
- `hi`/`lo` hold their last result until the next FIX. They do not change during CALC.
- `start` while `busy`=1 is ignored. Operand changes after the start cycle have no effect.

## Timing
- Reset (`rst`=0, asynchronous): state goes to IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- Reset mid-operation aborts the operation. No `done` pulse is issued for it.
- If `start` is sampled at rising edge k:
  - `busy`=1 from after edge k until after edge k+33.
  - At edge k+33, `hi`/`lo` update, `done`=1 and `busy`=0 for that one cycle.
- Latency is 33 cycles from start edge to result edge, for every op including divide by zero.
- `done` is high for exactly one cycle per accepted start.
- A new `start` is accepted at edge k+34 at the earliest.
  - `start`=1 during the `done` cycle is accepted at edge k+34.
  - Back-to-back throughput is one operation per 34 cycles.
- `done` and `busy` are never both 1.

## Test plan
- **MULTU**: `a`=32'hFFFFFFFF, `b`=32'hFFFFFFFF.
  - Expect `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
  - `done` exactly 33 cycles after the start edge; `busy` high 33 cycles.
- **MULT**: `a`=32'hFFFFFFFE (-2), `b`=3 → `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFFA.
- **MULT**: `a`=32'h80000000, `b`=32'h80000000 → `hi`=32'h40000000, `lo`=0.
- **DIV**: `a`=32'hFFFFFFF9 (-7), `b`=2 → `lo`=32'hFFFFFFFD, `hi`=32'hFFFFFFFF.
- **DIV**: `a`=7, `b`=32'hFFFFFFFE → `lo`=32'hFFFFFFFD, `hi`=1.
- **DIVU**: `a`=7, `b`=0 → `lo`=32'hFFFFFFFF, `hi`=7.
- **DIV overflow**: `a`=32'h80000000, `b`=32'hFFFFFFFF → `lo`=32'h80000000, `hi`=0.
- **Handshake and reset**:
  - Start a MULTU of 5×6, then pulse `start` with new operands at cycle 10 → second start ignored; result `hi`=0, `lo`=30.
  - Assert `rst`=0 at cycle 20 of a following op → `busy`, `done`, `hi`, `lo` all go to 0 immediately, with no `done` pulse afterwards.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32x32 MULT/MULTU/DIV/DIVU engine; result 33 cycles after the start edge, done pulse with hi/lo.
// No backpressure: start is ignored while busy, accepted again in the done cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        in_signed, a_neg, b_neg;
    logic [31:0] mag_a_in, mag_b_in;
    logic [32:0] mul_sum;
    logic [63:0] acc_mul;
    logic [31:0] rem_lo, rem_diff, rem_next;
    logic        rem_ge;
    logic [63:0] acc_div;
    logic [63:0] prod_fix;

    assign in_signed = ~op[0];
    assign a_neg     = in_signed & a[31];
    assign b_neg     = in_signed & b[31];
    assign mag_a_in  = a_neg ? (~a + 32'd1) : a;
    assign mag_b_in  = b_neg ? (~b + 32'd1) : b;

    // Shift-add: multiplier sits in acc[31:0] and is consumed LSB first.
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_b_q} : 33'd0);
    assign acc_mul = {mul_sum, acc_q[31:1]};

    // Restoring step; a set acc[63] means the shifted remainder already exceeds any divisor.
    assign rem_lo   = {acc_q[62:32], acc_q[31]};
    assign rem_diff = rem_lo - mag_b_q;
    assign rem_ge   = acc_q[63] | (rem_lo >= mag_b_q);
    assign rem_next = rem_ge ? rem_diff : rem_lo;
    assign acc_div  = {rem_next, acc_q[30:0], rem_ge};

    assign prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        a_raw_d   = a_raw_q;
        mag_b_d   = mag_b_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    a_raw_d   = a;
                    mag_b_d   = mag_b_in;
                    acc_d     = {32'd0, mag_a_in};
                    cnt_d     = 5'd0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                acc_d = is_div_q ? acc_div : acc_mul;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (mag_b_q == 32'd0) begin
                    hi_d = a_raw_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
                    lo_d = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_raw_q   <= 32'd0;
            mag_b_q   <= 32'd0;
            acc_q     <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            a_raw_q   <= a_raw_d;
            mag_b_q   <= mag_b_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency/busy timing, start-while-busy, async reset abort.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst_n),
        .start (start),
        .op    (op_i),
        .a     (a_i),
        .b     (b_i),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the next posedge (edge k).
    // Returns at the negedge of the done cycle so a following call starts during done.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit glitch);
        int j;
        int busy_n;
        int hold_err;
        start = 1'b1;
        op_i  = o;
        a_i   = x;
        b_i   = y;
        @(negedge clk);
        start = 1'b0;
        op_i  = ~o;
        a_i   = $urandom;
        b_i   = $urandom;
        j = 0;
        busy_n = 0;
        hold_err = 0;
        while (!done && j < 100) begin
            if (busy) busy_n++;
            if (hi !== last_hi || lo !== last_lo) hold_err++;
            if (glitch && j == 9) begin
                start = 1'b1;
                op_i  = OP_MULTU;
                a_i   = 32'd7;
                b_i   = 32'd8;
            end else if (glitch && j == 10) begin
                start = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        check_eq({tag, "_latency"}, 64'(j), 64'd33);
        check_eq({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
        check_eq({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        check_eq({tag, "_hold"}, 64'(hold_err), 64'd0);
        check_eq({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check_eq({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        last_hi = exp_hi;
        last_lo = exp_lo;
    endtask

    initial begin
        int dones;
        rst_n = 1'b1;
        start = 1'b0;
        op_i  = 2'b00;
        a_i   = 32'd0;
        b_i   = 32'd0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_hi", {32'd0, hi}, 64'd0);
        check_eq("rst_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg2x3", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("mult_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("multu_shift", OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0);
        run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b0);
        run_op("div_by0_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("multu_ignore", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b1);

        @(negedge clk);
        check_eq("done_one_cycle", {63'd0, done}, 64'd0);

        // Abort an operation with an asynchronous reset at cycle 20.
        start = 1'b1;
        op_i  = OP_MULTU;
        a_i   = 32'd3;
        b_i   = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check_eq("pre_abort_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_done", {63'd0, done}, 64'd0);
        check_eq("abort_hi", {32'd0, hi}, 64'd0);
        check_eq("abort_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("abort_no_done", 64'(dones), 64'd0);
        check_eq("abort_idle", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
